perips_timer_mc: RTL and testbench



---
 rtl/perips_timer_pkg.sv | 43 ++++
 rtl/perips_timer_ch.sv | 107 ++++++++++
 rtl/perips_timer_mc.sv | 105 ++++++++++
 tb/tb_perips_timer_mc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perips_timer_pkg.sv
// Shared register map, bit positions and types for the multi-channel peripheral timer.
// Optional PWM/compare logic is enabled by defining PERIPS_TIMER_PWM_EN.
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

package perips_timer_pkg;

  localparam logic [4:0] REG_CR    = 5'h00;
  localparam logic [4:0] REG_SR    = 5'h04;
  localparam logic [4:0] REG_PSC   = 5'h08;
  localparam logic [4:0] REG_LOAD  = 5'h0C;
  localparam logic [4:0] REG_COUNT = 5'h10;
  localparam logic [4:0] REG_CMP   = 5'h14;

  localparam logic [7:0] REG_IRQ_STAT = 8'hF0;
  localparam logic [7:0] REG_ID       = 8'hF4;

  localparam int unsigned CR_EN      = 0;
  localparam int unsigned CR_ONESHOT = 1;
  localparam int unsigned CR_IE      = 2;
  localparam int unsigned SR_UIF     = 0;

  localparam int unsigned CH_STRIDE = 32'h20;
  localparam int unsigned CH_SHIFT  = 5;

  localparam logic [15:0] ID_MAGIC = 16'h544D;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_e;

  typedef struct packed {
    logic cr;
    logic sr;
    logic psc;
    logic load;
    logic count;
    logic cmp;
  } ch_we_t;

endpackage

// File: rtl/perips_timer_ch.sv
// One timer channel: prescaler, down-counter, IDLE/RUN state, sticky UIF, irq register.
// CMP register and registered PWM output exist only when PERIPS_TIMER_PWM_EN is defined.
module perips_timer_ch
  import perips_timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  ch_we_t               we,
  input  logic [2:0]           ctrl,
  input  logic [CNT_WIDTH-1:0] wdata,
  output logic [2:0]           cr,
  output logic                 uif,
  output logic [CNT_WIDTH-1:0] psc,
  output logic [CNT_WIDTH-1:0] load,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] cmp,
  output logic                 irq,
  output logic                 pwm
);

  ch_state_e            state, state_next;
  logic                 oneshot;
  logic                 ie;
  logic [CNT_WIDTH-1:0] psc_cnt;
  logic                 tick;
  logic                 expire;
  logic                 start;

  assign tick   = (state == CH_RUN) && (psc_cnt == psc);
  assign expire = tick && (count == '0);
  assign cr     = {ie, oneshot, state == CH_RUN};

  // An EN=1 write that lands on a one-shot expiry counts as a fresh start.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    if (we.cr) begin
      if (ctrl[CR_EN]) begin
        start      = (state == CH_IDLE) || (expire && oneshot);
        state_next = CH_RUN;
      end else begin
        state_next = CH_IDLE;
      end
    end else if (expire && oneshot) begin
      state_next = CH_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CH_IDLE;
      oneshot <= 1'b0;
      ie      <= 1'b0;
      uif     <= 1'b0;
      psc     <= '0;
      load    <= '0;
      count   <= '0;
      psc_cnt <= '0;
      irq     <= 1'b0;
    end else begin
      state <= state_next;
      if (we.cr) begin
        oneshot <= ctrl[CR_ONESHOT];
        ie      <= ctrl[CR_IE];
      end
      if (we.psc)  psc  <= wdata;
      if (we.load) load <= wdata;

      if (state_next == CH_IDLE || start || tick) psc_cnt <= '0;
      else                                        psc_cnt <= psc_cnt + 1'b1;

      if (we.count) begin
        count <= wdata;
      end else if (start) begin
        count <= load;
      end else if (tick) begin
        if (count != '0)   count <= count - 1'b1;
        else if (!oneshot) count <= load;
      end

      if (expire)                        uif <= 1'b1;
      else if (we.sr && ctrl[SR_UIF])    uif <= 1'b0;

      irq <= uif & ie;
    end
  end

`ifdef PERIPS_TIMER_PWM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp <= '0;
      pwm <= 1'b0;
    end else begin
      if (we.cmp) cmp <= wdata;
      pwm <= (state == CH_RUN) && (count < cmp);
    end
  end
`else
  logic unused_cmp_we;
  assign unused_cmp_we = we.cmp;
  assign cmp = '0;
  assign pwm = 1'b0;
`endif

endmodule

// File: rtl/perips_timer_mc.sv
// Multi-channel peripheral timer: address decode, write fan-out, registered read mux, irq OR.
// Define PERIPS_TIMER_PWM_EN to add per-channel CMP registers and PWM outputs.
module perips_timer_mc
  import perips_timer_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = `DATA_BUS_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            addr_i,
  input  logic                  data_rd_i,
  input  logic                  data_we_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]     irq_ch_o,
  output logic                  irq_o,
  output logic [NUM_CH-1:0]     pwm_o
);

  logic [2:0]            ch_sel;
  logic [4:0]            offs;
  logic [CNT_WIDTH-1:0]  wdata;
  logic                  unused_data;
  ch_we_t                we_ch  [NUM_CH];
  logic [2:0]            cr_ch  [NUM_CH];
  logic [NUM_CH-1:0]     uif_ch;
  logic [CNT_WIDTH-1:0]  psc_ch [NUM_CH];
  logic [CNT_WIDTH-1:0]  load_ch[NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_ch [NUM_CH];
  logic [CNT_WIDTH-1:0]  cmp_ch [NUM_CH];
  logic [DATA_WIDTH-1:0] rd_val;

  assign ch_sel      = addr_i[7:CH_SHIFT];
  assign offs        = addr_i[CH_SHIFT-1:0];
  assign wdata       = data_i[CNT_WIDTH-1:0];
  assign unused_data = ^data_i;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      we_ch[c] = '0;
      if (data_we_i && ch_sel == 3'(c)) begin
        we_ch[c].cr    = (offs == REG_CR);
        we_ch[c].sr    = (offs == REG_SR);
        we_ch[c].psc   = (offs == REG_PSC);
        we_ch[c].load  = (offs == REG_LOAD);
        we_ch[c].count = (offs == REG_COUNT);
        we_ch[c].cmp   = (offs == REG_CMP);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    perips_timer_ch #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_ch (
      .clk  (clk_i),
      .rst  (rst_i),
      .we   (we_ch[c]),
      .ctrl (data_i[2:0]),
      .wdata(wdata),
      .cr   (cr_ch[c]),
      .uif  (uif_ch[c]),
      .psc  (psc_ch[c]),
      .load (load_ch[c]),
      .count(cnt_ch[c]),
      .cmp  (cmp_ch[c]),
      .irq  (irq_ch_o[c]),
      .pwm  (pwm_o[c])
    );
  end

  assign irq_o = |irq_ch_o;

  // Global registers sit in the channel-7 window, which is never a real channel.
  always_comb begin
    rd_val = '0;
    if (addr_i == REG_IRQ_STAT) begin
      rd_val = DATA_WIDTH'(irq_ch_o);
    end else if (addr_i == REG_ID) begin
      rd_val = DATA_WIDTH'({ID_MAGIC, 8'(NUM_CH), 8'(CNT_WIDTH)});
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 3'(c)) begin
          case (offs)
            REG_CR:    rd_val = DATA_WIDTH'(cr_ch[c]);
            REG_SR:    rd_val = DATA_WIDTH'(uif_ch[c]);
            REG_PSC:   rd_val = DATA_WIDTH'(psc_ch[c]);
            REG_LOAD:  rd_val = DATA_WIDTH'(load_ch[c]);
            REG_COUNT: rd_val = DATA_WIDTH'(cnt_ch[c]);
            REG_CMP:   rd_val = DATA_WIDTH'(cmp_ch[c]);
            default:   rd_val = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          data_o <= '0;
    else if (data_rd_i) data_o <= rd_val;
  end

endmodule

// File: tb/tb_perips_timer_mc.sv
// Self-checking bench for perips_timer_mc (NUM_CH=4, CNT_WIDTH=8): directed scenarios plus
// randomized bus traffic compared every cycle against a behavioural register/timer model.
module tb_perips_timer_mc;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned MASK = 32'hFF;
`ifdef PERIPS_TIMER_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             bus_rst, bus_rd, bus_we;
  logic [7:0]       bus_addr;
  logic [31:0]      bus_wd;
  logic [31:0]      data_o;
  logic [NCH-1:0]   irq_ch_o, pwm_o;
  logic             irq_o;

  int unsigned nvec = 0, nerr = 0, cyc_n = 0;

  int unsigned m_en[NCH], m_os[NCH], m_ie[NCH], m_uif[NCH];
  int unsigned m_psc[NCH], m_load[NCH], m_cnt[NCH], m_cmp[NCH], m_pc[NCH];
  logic [NCH-1:0] m_irq, m_pwm;
  logic [31:0]    m_dout;

  perips_timer_mc #(.NUM_CH(NCH), .CNT_WIDTH(CW), .DATA_WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (bus_rst),
    .addr_i   (bus_addr),
    .data_rd_i(bus_rd),
    .data_we_i(bus_we),
    .data_i   (bus_wd),
    .data_o   (data_o),
    .irq_ch_o (irq_ch_o),
    .irq_o    (irq_o),
    .pwm_o    (pwm_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int unsigned c = a / 32;
    int unsigned o = a % 32;
    if (a == 8'hF0) return 32'(m_irq);
    if (a == 8'hF4) return {16'h544D, 8'(NCH), 8'(CW)};
    if (c >= NCH) return 0;
    case (o)
      0:  return m_en[c] | (m_os[c] << 1) | (m_ie[c] << 2);
      4:  return m_uif[c];
      8:  return m_psc[c];
      12: return m_load[c];
      16: return m_cnt[c];
      20: return PWM ? m_cmp[c] : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    logic [NCH-1:0] n_irq, n_pwm;
    if (bus_rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_en[c] = 0; m_os[c] = 0; m_ie[c] = 0; m_uif[c] = 0; m_psc[c] = 0;
        m_load[c] = 0; m_cnt[c] = 0; m_cmp[c] = 0; m_pc[c] = 0;
      end
      m_irq = '0; m_pwm = '0; m_dout = 0;
      return;
    end
    if (bus_rd) m_dout = m_read(bus_addr);
    for (int c = 0; c < NCH; c++) begin
      bit tk, ex, hit, rearm, old_en, old_os;
      int unsigned o, d;
      tk     = (m_en[c] != 0) && (m_pc[c] == m_psc[c]);
      ex     = tk && (m_cnt[c] == 0);
      hit    = bus_we && (bus_addr / 32 == c);
      o      = bus_addr % 32;
      d      = bus_wd;
      old_en = m_en[c] != 0;
      old_os = m_os[c] != 0;
      n_irq[c] = (m_uif[c] != 0) && (m_ie[c] != 0);
      n_pwm[c] = PWM && old_en && (m_cnt[c] < m_cmp[c]);
      if (tk) begin
        m_pc[c] = 0;
        if (m_cnt[c] != 0) m_cnt[c]--;
        else if (!old_os)  m_cnt[c] = m_load[c];
        else               m_en[c] = 0;
      end else if (old_en) begin
        m_pc[c] = (m_pc[c] + 1) & MASK;
      end
      if (ex) m_uif[c] = 1;
      if (hit) begin
        case (o)
          0: begin
            rearm   = d[0] && (!old_en || (ex && old_os));
            m_en[c] = d[0]; m_os[c] = d[1]; m_ie[c] = d[2];
            if (rearm) begin m_cnt[c] = m_load[c]; m_pc[c] = 0; end
            if (!d[0]) m_pc[c] = 0;
          end
          4:  if (d[0] && !ex) m_uif[c] = 0;
          8:  m_psc[c]  = d & MASK;
          12: m_load[c] = d & MASK;
          16: m_cnt[c]  = d & MASK;
          20: if (PWM) m_cmp[c] = d & MASK;
          default: ;
        endcase
      end
    end
    m_irq = n_irq;
    m_pwm = n_pwm;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc_n++;
    chk("data_o", data_o, m_dout);
    chk("irq_ch_o", 32'(irq_ch_o), 32'(m_irq));
    chk("irq_o", 32'(irq_o), 32'(|m_irq));
    chk("pwm_o", 32'(pwm_o), 32'(m_pwm));
  endtask

  task automatic idle();
    bus_rst = 0; bus_rd = 0; bus_we = 0;
    tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_rst = 0; bus_rd = 0; bus_we = 1; bus_addr = a; bus_wd = d;
    tick();
    bus_we = 0;
  endtask

  task automatic rdreg(input logic [7:0] a, output logic [31:0] v);
    bus_rst = 0; bus_rd = 1; bus_we = 0; bus_addr = a;
    tick();
    bus_rd = 0;
    v = data_o;
  endtask

  initial begin
    logic [31:0] v;
    int unsigned n, hi;
    bus_rst = 1; bus_rd = 0; bus_we = 0; bus_addr = '0; bus_wd = '0;
    tick(); tick();
    chk("rst_data", data_o, 0);
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_pwm", 32'(pwm_o), 0);

    // periodic ch0: PSC=1 LOAD=3 -> expiry every 8 cycles
    wr(8'h08, 1); wr(8'h0C, 3); wr(8'h00, 5);
    n = 0;
    while (!irq_ch_o[0] && n < 40) begin idle(); n++; end
    chk("per_first_irq_cycles", n, 9);
    wr(8'h04, 1);
    chk("w1c_irq_hold", 32'(irq_ch_o[0]), 1);
    idle();
    chk("w1c_irq_fall", 32'(irq_ch_o[0]), 0);
    n = 0;
    while (!irq_ch_o[0] && n < 40) begin idle(); n++; end
    chk("per_period_cycles", n, 6);
    rdreg(8'hF0, v);
    chk("irq_stat", v, 1);
    wr(8'h00, 0); wr(8'h04, 1);

    // one-shot ch1: LOAD=2 PSC=0
    wr(8'h2C, 2); wr(8'h20, 3);
    idle(); idle();
    rdreg(8'h24, v); chk("os_uif_early", v, 0);
    rdreg(8'h24, v); chk("os_uif_set", v, 1);
    rdreg(8'h20, v); chk("os_cr", v, 2);
    rdreg(8'h30, v); chk("os_count", v, 0);
    wr(8'h24, 1);
    repeat (50) idle();
    rdreg(8'h24, v); chk("os_no_reexpire", v, 0);
    rdreg(8'h30, v); chk("os_count_held", v, 0);

    // simultaneous W1C/expiry and COUNT write/tick on ch2
    wr(8'h48, 0); wr(8'h4C, 3); wr(8'h40, 1);
    idle(); idle(); idle();
    wr(8'h44, 1);
    rdreg(8'h44, v); chk("set_beats_clear", v, 1);
    wr(8'h50, 32'h10);
    rdreg(8'h50, v); chk("cnt_write_beats_tick", v, 32'h10);
    wr(8'h40, 0); wr(8'h44, 1);

    // width, decode, ID, read latency
    wr(8'h6C, 32'h1FF);
    rdreg(8'h6C, v); chk("load_trunc", v, 32'hFF);
    idle(); chk("rd_hold", data_o, 32'hFF);
    wr(8'h8C, 32'h55);
    rdreg(8'h8C, v); chk("unmapped_ch", v, 0);
    rdreg(8'h78, v); chk("unmapped_off", v, 0);
    bus_rd = 1; bus_addr = 8'hF4;
    chk("rd_not_early", data_o, 0);
    tick(); bus_rd = 0;
    chk("id", data_o, 32'h544D_0408);

    // reset mid-run
    wr(8'h08, 0); wr(8'h0C, 200); wr(8'h00, 5); wr(8'h10, 5);
    bus_rst = 1; tick(); bus_rst = 0;
    chk("midrst_irq", 32'(irq_o), 0);
    chk("midrst_pwm", 32'(pwm_o), 0);
    chk("midrst_data", data_o, 0);
    rdreg(8'h10, v); chk("midrst_count", v, 0);
    rdreg(8'h00, v); chk("midrst_cr", v, 0);
    rdreg(8'h6C, v); chk("midrst_load3", v, 0);

    // PWM
    wr(8'h0C, 9); wr(8'h14, 3); wr(8'h00, 1);
`ifdef PERIPS_TIMER_PWM_EN
    rdreg(8'h14, v); chk("cmp_rd", v, 3);
    repeat (12) idle();
    hi = 0; repeat (10) begin idle(); hi += pwm_o[0]; end
    chk("pwm_duty", hi, 3);
    wr(8'h14, 0); idle(); idle();
    hi = 0; repeat (20) begin idle(); hi += pwm_o[0]; end
    chk("pwm_cmp0_low", hi, 0);
    wr(8'h14, 10); idle(); idle();
    hi = 0; repeat (20) begin idle(); hi += pwm_o[0]; end
    chk("pwm_cmp_gt_load_high", hi, 20);
`else
    rdreg(8'h14, v); chk("cmp_absent", v, 0);
    hi = 0; repeat (20) begin idle(); hi += (pwm_o != '0); end
    chk("pwm_tied_low", hi, 0);
`endif
    wr(8'h00, 0);

    // randomized traffic against the model
    bus_rst = 1; tick(); bus_rst = 0;
    for (int i = 0; i < 1500; i++) begin
      int unsigned op, c, o, d;
      op = $urandom_range(0, 9);
      c  = $urandom_range(0, 1);
      o  = $urandom_range(0, 5) * 4;
      case (o)
        0:  d = $urandom_range(0, 7);
        4:  d = $urandom_range(0, 1);
        8:  d = $urandom_range(0, 3);
        default: d = $urandom_range(0, 12) | ($urandom_range(0, 1) << 8);
      endcase
      bus_rst = ($urandom_range(0, 299) == 0);
      bus_rd  = 0; bus_we = 0; bus_wd = d;
      bus_addr = 8'(c * 32 + o);
      if (op < 4) begin
        bus_we = 1;
      end else if (op < 7) begin
        bus_rd = 1;
        if ($urandom_range(0, 7) == 0) bus_addr = $urandom_range(0, 1) ? 8'hF0 : 8'hF4;
        else bus_addr = 8'($urandom_range(0, 4) * 32 + o);
      end else if (op == 7) begin
        bus_rd = 1; bus_we = 1;
      end
      tick();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
